video_system_switch_ctrl: RTL and testbench
===========================================

VIDEO_SYSTEM_SWITCH_CTRL -- requirements
Module: video_system_switch_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of switch inputs (1..16).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, number of consecutive stable cycles before a debounced bit changes (>=2).
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port address  input  2  Avalon-MM word address.
REQ-006 SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-007 SHALL have port write_n  input  1  Avalon-MM write strobe, active-low.
REQ-008 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-009 SHALL have port readdata  output  32  Avalon-MM read data, registered.
REQ-010 SHALL have port in_port  input  WIDTH  raw asynchronous switch levels.
REQ-011 SHALL have port irq  output  1  level interrupt, active-high.

Function
REQ-012 SHALL pass each in_port bit through a 2-flop synchronizer before any other use.
REQ-013 SHALL keep one debounced bit and one stability counter per input: counter clears when sync bit equals debounced bit; otherwise increments; on reaching DEBOUNCE_CYCLES-1 while different, debounced bit takes the sync value on the next edge and the counter clears.
REQ-014 SHALL make a debounced change visible DEBOUNCE_CYCLES+2 cycles after a stable in_port change (2 sync + DEBOUNCE_CYCLES); glitches shorter than DEBOUNCE_CYCLES SHALL produce no change.
REQ-015 SHALL implement register map: 0 DATA (RO, debounced bits, zero-extended); 1 IRQ_MASK (RW, bits WIDTH-1:0); 2 EDGE_SEL (RW, bits WIDTH-1:0 rising enable, bits WIDTH+15:16 falling enable); 3 EDGE_CAP (read; write-1-to-clear).
REQ-016 SHALL perform a write when chipselect=1 and write_n=0; writes to address 0 and to unimplemented bits SHALL be ignored; unimplemented bits SHALL read 0.
REQ-017 SHALL update readdata every cycle with the register selected by address, giving read latency 1; reads SHALL have no side effects.
REQ-018 SHALL set EDGE_CAP[i] the cycle after debounced bit i rises with EDGE_SEL rising[i]=1, or falls with falling[i]=1.
REQ-019 SHALL give set priority over clear when an edge and a write-1-to-clear hit the same bit in the same cycle (bit stays 1).
REQ-020 SHALL drive irq = OR over i of (EDGE_CAP[i] AND IRQ_MASK[i]), from registered state with no further delay.
REQ-021 SHALL keep EDGE_CAP bits set while masked; unmasking a set bit SHALL assert irq on the same cycle IRQ_MASK updates.

Reset
REQ-022 SHALL, while reset_n=0, clear synchronizers, debounced bits, counters, IRQ_MASK, EDGE_SEL, EDGE_CAP and readdata to 0, and hold irq at 0.
REQ-023 SHALL treat a switch high at reset release as a normal rising transition (debounced after DEBOUNCE_CYCLES+2 cycles, captured if enabled).
REQ-024 SHALL abandon any in-progress debounce count when reset asserts mid-operation.

Structure
REQ-025 SHALL take register address constants (ADDR_DATA=0, ADDR_IRQ_MASK=1, ADDR_EDGE_SEL=2, ADDR_EDGE_CAP=3) and the EDGE_SEL falling-field offset (16) from shared package video_system_switch_pkg.
REQ-026 SHALL instantiate WIDTH copies of sub-module video_system_switch_debounce (one bit: synchronizer, counter, debounced output, rise/fall pulses).

Verification (DEBOUNCE_CYCLES=4, WIDTH=8)
REQ-027 SHALL cover: in_port 0x00->0x01 held -> DATA reads 0x00000001 from cycle 6 after change, 0 before.
REQ-028 SHALL cover: in_port bit0 pulse high 3 cycles -> DATA stays 0x00000000, EDGE_CAP stays 0.
REQ-029 SHALL cover: EDGE_SEL=0x00000001, IRQ_MASK=0x01, bit0 0->1 -> EDGE_CAP=0x00000001, irq=1; write 0x1 to EDGE_CAP -> irq=0 next cycle.
REQ-030 SHALL cover: EDGE_SEL=0x00800000, bit7 1->0 with IRQ_MASK=0 -> EDGE_CAP=0x00000080, irq=0; then IRQ_MASK=0x80 -> irq=1.
REQ-031 SHALL cover: clear write to EDGE_CAP bit0 coinciding with a new bit0 edge -> EDGE_CAP bit0 remains 1.
REQ-032 SHALL cover: reset_n low for 1 cycle mid-debounce with IRQ_MASK=0xFF -> all registers read 0, irq=0; write to address 0 of 0xFF -> DATA unchanged.

Source files
------------

// File: rtl/video_system_switch_pkg.sv
// Shared register map and field offsets for the switch controller.
// Constants only; no latency or backpressure.
package video_system_switch_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE_SEL = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    // EDGE_SEL holds rising enables in the low field, falling enables from here up.
    localparam int EDGE_SEL_FALL_OFS = 16;

endpackage

// File: rtl/video_system_switch_debounce.sv
// One switch bit: 2-flop synchronizer, stability counter, debounced level, edge pulses.
// Latency: DEBOUNCE_CYCLES+2 cycles from stable input to debounced level; pulses coincide with it.
// Backpressure: none; free-running.
module video_system_switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic deb,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            deb_d  = sync2_q;
            cnt_d  = '0;
            rise_d = sync2_q;
            fall_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb  = deb_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/video_system_switch_ctrl.sv
// Debounced switch bank with Avalon-MM registers, edge capture and level interrupt.
// Latency: read data 1 cycle; edge capture 1 cycle after the debounced change.
// Backpressure: none; slave accepts every access with no wait states.
module video_system_switch_ctrl
    import video_system_switch_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] deb, rise, fall;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        video_system_switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (in_port[i]),
            .deb    (deb[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    logic             wr_en;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    always_comb begin
        mask_d    = mask_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr       = '0;
        if (wr_en && address == ADDR_IRQ_MASK) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == ADDR_EDGE_SEL) begin
            rise_en_d = writedata[WIDTH-1:0];
            fall_en_d = writedata[EDGE_SEL_FALL_OFS +: WIDTH];
        end
        if (wr_en && address == ADDR_EDGE_CAP) begin
            clr = writedata[WIDTH-1:0];
        end
        // A new edge wins over a simultaneous write-1-to-clear.
        cap_d = (cap_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);

        rdata_d = '0;
        case (address)
            ADDR_DATA:     rdata_d[WIDTH-1:0] = deb;
            ADDR_IRQ_MASK: rdata_d[WIDTH-1:0] = mask_q;
            ADDR_EDGE_SEL: begin
                rdata_d[WIDTH-1:0]                 = rise_en_q;
                rdata_d[EDGE_SEL_FALL_OFS +: WIDTH] = fall_en_q;
            end
            ADDR_EDGE_CAP: rdata_d[WIDTH-1:0] = cap_q;
            default:       rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            cap_q     <= '0;
            rdata_q   <= '0;
        end else begin
            mask_q    <= mask_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            cap_q     <= cap_d;
            rdata_q   <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_video_system_switch_ctrl.sv
// Directed bench for video_system_switch_ctrl with DEBOUNCE_CYCLES=4, WIDTH=8.
// Read expectations are queued when the address is driven and checked when readdata lands.
module tb_video_system_switch_ctrl;
    import video_system_switch_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic        irq;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    video_system_switch_ctrl #(
        .WIDTH          (8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_irq(input logic exp, input string tag);
        checks++;
        assert (irq === exp) else begin
            errors++;
            $error("FAIL %s: irq=%b expected %b", tag, irq, exp);
        end
    endtask

    task automatic chk_rdata_now(input logic [31:0] exp, input string tag);
        checks++;
        assert (readdata === exp) else begin
            errors++;
            $error("FAIL %s: readdata=%h expected %h", tag, readdata, exp);
        end
    endtask

    // Drive a read, queue its expectation, then check it when readdata updates.
    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] e;
        string       t;
        address = a;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick();
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (readdata === e) else begin
            errors++;
            $error("FAIL %s: readdata=%h expected %h", t, readdata, e);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = ADDR_DATA;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 8'h00;
        repeat (3) tick();
        chk_rdata_now(32'h0, "reset_readdata");
        chk_irq(1'b0, "reset_irq");
        reset_n = 1'b1;
        tick();

        // Stable rise on bit0: debounced after 6 edges, seen on readdata one edge later.
        in_port = 8'h01;
        for (int k = 1; k <= 9; k++) rd(ADDR_DATA, (k >= 7) ? 32'h1 : 32'h0, "data_rise");
        rd(ADDR_EDGE_CAP, 32'h0, "cap_no_sel");
        in_port = 8'h00;
        repeat (10) tick();
        rd(ADDR_DATA, 32'h0, "data_fall");

        // 3-cycle glitch must be filtered even with both edges enabled.
        wr(ADDR_EDGE_SEL, 32'h0001_0001);
        in_port = 8'h01;
        repeat (3) tick();
        in_port = 8'h00;
        for (int k = 1; k <= 10; k++) rd(ADDR_DATA, 32'h0, "glitch_data");
        rd(ADDR_EDGE_CAP, 32'h0, "glitch_cap");
        chk_irq(1'b0, "glitch_irq");

        // Rising capture with irq, then write-1-to-clear.
        wr(ADDR_EDGE_SEL, 32'h0000_0001);
        wr(ADDR_IRQ_MASK, 32'h0000_0001);
        in_port = 8'h01;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk_irq(k >= 7, "rise_irq_timing");
        end
        rd(ADDR_EDGE_CAP, 32'h1, "rise_cap");
        rd(ADDR_IRQ_MASK, 32'h1, "mask_rb");
        rd(ADDR_EDGE_SEL, 32'h1, "esel_rb");
        chk_irq(1'b1, "rise_irq_held");
        wr(ADDR_EDGE_CAP, 32'h1);
        chk_irq(1'b0, "clear_irq");
        rd(ADDR_EDGE_CAP, 32'h0, "clear_cap");

        // Falling capture on bit7 while masked, then unmask.
        in_port = 8'h81;
        repeat (10) tick();
        rd(ADDR_EDGE_CAP, 32'h0, "bit7_rise_not_sel");
        wr(ADDR_IRQ_MASK, 32'h0);
        wr(ADDR_EDGE_SEL, 32'h0080_0000);
        rd(ADDR_EDGE_SEL, 32'h0080_0000, "esel_fall_rb");
        in_port = 8'h01;
        for (int k = 1; k <= 9; k++) begin
            rd(ADDR_EDGE_CAP, (k >= 8) ? 32'h80 : 32'h0, "fall_cap_timing");
            chk_irq(1'b0, "fall_masked_irq");
        end
        wr(ADDR_IRQ_MASK, 32'h80);
        chk_irq(1'b1, "unmask_irq");
        wr(ADDR_EDGE_CAP, 32'h80);
        chk_irq(1'b0, "clear_bit7_irq");

        // Clear coinciding with a new edge on bit0: set wins.
        wr(ADDR_EDGE_SEL, 32'h0001_0001);
        wr(ADDR_IRQ_MASK, 32'h1);
        in_port = 8'h00;
        repeat (10) tick();
        chk_irq(1'b1, "bit0_fall_irq");
        rd(ADDR_EDGE_CAP, 32'h1, "bit0_fall_cap");
        in_port = 8'h01;
        repeat (6) tick();
        wr(ADDR_EDGE_CAP, 32'h1);
        chk_irq(1'b1, "set_wins_irq");
        rd(ADDR_EDGE_CAP, 32'h1, "set_wins_cap");
        wr(ADDR_EDGE_CAP, 32'h1);
        chk_irq(1'b0, "plain_clear_irq");

        // Mid-debounce reset with live state everywhere.
        wr(ADDR_IRQ_MASK, 32'hFF);
        in_port = 8'h80;
        repeat (10) tick();
        chk_irq(1'b1, "pre_reset_irq");
        rd(ADDR_DATA, 32'h80, "pre_reset_data");
        in_port = 8'h00;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        chk_irq(1'b0, "reset_async_irq");
        tick();
        chk_rdata_now(32'h0, "reset_mid_readdata");
        reset_n = 1'b1;
        rd(ADDR_DATA, 32'h0, "post_reset_data");
        rd(ADDR_IRQ_MASK, 32'h0, "post_reset_mask");
        rd(ADDR_EDGE_SEL, 32'h0, "post_reset_esel");
        rd(ADDR_EDGE_CAP, 32'h0, "post_reset_cap");
        chk_irq(1'b0, "post_reset_irq");
        wr(ADDR_DATA, 32'hFF);
        rd(ADDR_DATA, 32'h0, "data_ro");
        rd(ADDR_IRQ_MASK, 32'h0, "data_wr_no_leak");

        // Switch already high at reset release behaves as a normal rise.
        reset_n = 1'b0;
        in_port = 8'h01;
        tick();
        reset_n = 1'b1;
        wr(ADDR_EDGE_SEL, 32'h1);
        wr(ADDR_IRQ_MASK, 32'h1);
        for (int k = 3; k <= 8; k++) begin
            tick();
            chk_irq(k >= 7, "release_high_irq");
        end
        rd(ADDR_DATA, 32'h1, "release_high_data");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
